// File: rtl/keypad_pkg.sv
// Shared constants for the keypad encoder: key codes, operator codes, FSM encoding and
// default timing parameters.
package keypad_pkg;

  localparam int unsigned DefScanCycles     = 1000;
  localparam int unsigned DefDebounceCycles = 100000;

  localparam int unsigned NumRows = 5;
  localparam int unsigned NumCols = 4;

  // Key code = row * 4 + col; codes not listed here are digits
  localparam logic [4:0] KeyBksp = 5'd3;
  localparam logic [4:0] KeyClr  = 5'd7;
  localparam logic [4:0] KeyAdd  = 5'd11;
  localparam logic [4:0] KeyZero = 5'd12;
  localparam logic [4:0] KeySub  = 5'd13;
  localparam logic [4:0] KeyEq   = 5'd14;
  localparam logic [4:0] KeyMul  = 5'd15;
  localparam logic [4:0] KeyMs   = 5'd16;
  localparam logic [4:0] KeyMr   = 5'd17;
  localparam logic [4:0] KeyMc   = 5'd18;
  localparam logic [4:0] KeyDiv  = 5'd19;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpDiv = 2'b11;

  typedef enum logic [2:0] {
    StScan    = 3'd0,
    StConfirm = 3'd1,
    StEmit    = 3'd2,
    StHeld    = 3'd3,
    StRelease = 3'd4
  } state_t;

  typedef struct packed {
    logic dig;
    logic op;
    logic sub;
    logic ex;
    logic bksp;
    logic clr;
    logic ms;
    logic mr;
    logic mc;
  } key_evt_t;

endpackage

// File: rtl/keypad_encoder_if.sv
// Keypad matrix lines plus the key-event bus towards the calculator control FSM.
interface keypad_encoder_if;
  import keypad_pkg::*;

  logic [NumRows-1:0] row_in;
  logic [NumCols-1:0] col_drive;
  logic               dig, op, sub, ex, bksp, clr, ms, mr, mc;
  logic [3:0]         digit;
  logic [1:0]         op_code;
  logic [4:0]         key_code;
  logic [2:0]         LED;

  modport master (
    input  row_in,
    output col_drive, dig, op, sub, ex, bksp, clr, ms, mr, mc, digit, op_code, key_code, LED
  );

  modport slave (
    output row_in,
    input  col_drive, dig, op, sub, ex, bksp, clr, ms, mr, mc, digit, op_code, key_code, LED
  );
endinterface

// File: rtl/key_decode.sv
// Combinational map from key code to event pulses, digit value and operator code.
module key_decode
  import keypad_pkg::*;
(
  input  logic [4:0] key_code,
  output key_evt_t   evt,
  output logic [3:0] digit,
  output logic [1:0] op_code
);

  always_comb begin
    evt     = '0;
    digit   = '0;
    op_code = OpAdd;
    case (key_code)
      5'd0:    begin evt.dig = 1'b1; digit = 4'd7; end
      5'd1:    begin evt.dig = 1'b1; digit = 4'd8; end
      5'd2:    begin evt.dig = 1'b1; digit = 4'd9; end
      5'd4:    begin evt.dig = 1'b1; digit = 4'd4; end
      5'd5:    begin evt.dig = 1'b1; digit = 4'd5; end
      5'd6:    begin evt.dig = 1'b1; digit = 4'd6; end
      5'd8:    begin evt.dig = 1'b1; digit = 4'd1; end
      5'd9:    begin evt.dig = 1'b1; digit = 4'd2; end
      5'd10:   begin evt.dig = 1'b1; digit = 4'd3; end
      KeyZero: begin evt.dig = 1'b1; digit = 4'd0; end
      KeyBksp: evt.bksp = 1'b1;
      KeyClr:  evt.clr  = 1'b1;
      KeyAdd:  begin evt.op = 1'b1; op_code = OpAdd; end
      // Minus doubles as a sign key, so the control FSM sees both sub and op
      KeySub:  begin evt.sub = 1'b1; evt.op = 1'b1; op_code = OpSub; end
      KeyEq:   evt.ex = 1'b1;
      KeyMul:  begin evt.op = 1'b1; op_code = OpMul; end
      KeyMs:   evt.ms = 1'b1;
      KeyMr:   evt.mr = 1'b1;
      KeyMc:   evt.mc = 1'b1;
      KeyDiv:  begin evt.op = 1'b1; op_code = OpDiv; end
      default: ;
    endcase
  end

endmodule

// File: rtl/keypad_encoder.sv
// 5x4 keypad scanner: synchronises rows, debounces press and release, and emits one
// key-event pulse per physical press.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = DefScanCycles,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input logic              clock,
  input logic              reset_n,
  keypad_encoder_if.master kp
);

  localparam int unsigned SW = $clog2(SCAN_CYCLES);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] ScanLast = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DebLast  = DW'(DEBOUNCE_CYCLES - 1);

  logic [NumRows-1:0] row_meta_q, row_sync_q, row_low;
  state_t             state_q, state_d;
  logic [1:0]         col_q, col_d;
  logic [SW-1:0]      scan_cnt_q, scan_cnt_d;
  logic [DW-1:0]      deb_cnt_q, deb_cnt_d;
  logic [2:0]         cap_row_q, cap_row_d, low_idx;
  logic [3:0]         digit_q, digit_d, dec_digit;
  logic [1:0]         op_code_q, op_code_d, dec_op_code;
  logic [4:0]         key_code_q, key_code_d, cap_code;
  logic               one_low, all_high, cap_alone, emit;
  key_evt_t           dec_evt;

  assign row_low   = ~row_sync_q;
  assign one_low   = $onehot(row_low);
  assign all_high  = &row_sync_q;
  assign cap_alone = (row_sync_q == ~(NumRows'(1) << cap_row_q));
  assign cap_code  = {cap_row_q, col_q};
  assign emit      = (state_q == StEmit);

  always_comb begin
    low_idx = '0;
    for (int unsigned i = 0; i < NumRows; i++) begin
      if (row_low[i]) low_idx = 3'(i);
    end
  end

  key_decode u_key_decode (
    .key_code (cap_code),
    .evt      (dec_evt),
    .digit    (dec_digit),
    .op_code  (dec_op_code)
  );

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    cap_row_d  = cap_row_q;
    digit_d    = digit_q;
    op_code_d  = op_code_q;
    key_code_d = key_code_q;
    unique case (state_q)
      StScan: begin
        if (scan_cnt_q == ScanLast) begin
          scan_cnt_d = '0;
          // Ghosted samples (several rows low) fall through and keep scanning
          if (one_low) begin
            state_d   = StConfirm;
            cap_row_d = low_idx;
            deb_cnt_d = '0;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SW'(1);
        end
      end
      StConfirm: begin
        if (!cap_alone) begin
          state_d   = StScan;
          deb_cnt_d = '0;
          col_d     = col_q + 2'd1;
        end else if (deb_cnt_q == DebLast) begin
          state_d    = StEmit;
          deb_cnt_d  = '0;
          key_code_d = cap_code;
          if (dec_evt.dig) digit_d = dec_digit;
          if (dec_evt.op) op_code_d = dec_op_code;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      StEmit: state_d = StHeld;
      StHeld: begin
        if (all_high) begin
          state_d   = StRelease;
          deb_cnt_d = '0;
        end
      end
      StRelease: begin
        if (!all_high) begin
          state_d   = StHeld;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          state_d    = StScan;
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
          col_d      = col_q + 2'd1;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      state_q    <= StScan;
      col_q      <= '0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      cap_row_q  <= '0;
      digit_q    <= '0;
      op_code_q  <= OpAdd;
      key_code_q <= '0;
    end else begin
      row_meta_q <= kp.row_in;
      row_sync_q <= row_meta_q;
      state_q    <= state_d;
      col_q      <= col_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      cap_row_q  <= cap_row_d;
      digit_q    <= digit_d;
      op_code_q  <= op_code_d;
      key_code_q <= key_code_d;
    end
  end

  assign kp.col_drive = ~(NumCols'(1) << col_q);
  assign kp.dig       = emit & dec_evt.dig;
  assign kp.op        = emit & dec_evt.op;
  assign kp.sub       = emit & dec_evt.sub;
  assign kp.ex        = emit & dec_evt.ex;
  assign kp.bksp      = emit & dec_evt.bksp;
  assign kp.clr       = emit & dec_evt.clr;
  assign kp.ms        = emit & dec_evt.ms;
  assign kp.mr        = emit & dec_evt.mr;
  assign kp.mc        = emit & dec_evt.mc;
  assign kp.digit     = digit_q;
  assign kp.op_code   = op_code_q;
  assign kp.key_code  = key_code_q;
  assign kp.LED       = state_q;

endmodule
